// File: rtl/core_dispatcher.sv
// core_dispatcher: buffers decoded instructions in a small FIFO and issues each
// one to an idle matrix core.
//
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-high reset
//   in_valid      - decoder presents in_inst
//   in_ready      - FIFO has room (fifo_count != FIFO_DEPTH)
//   in_inst       - decoded instruction word
//   core_start    - one-hot, one-cycle start pulse to the selected core
//   core_inst     - shared instruction bus, valid while core_start != 0
//   core_done     - per-core one-cycle completion pulse
//   core_busy     - per-core busy flag
//   fifo_count    - number of buffered instructions
//   idle          - FIFO empty, no core busy, no start in flight
//   timeout_err   - per-core sticky timeout flag (CORE_DISPATCH_TIMEOUT_EN only)
//
// Optional feature macro: CORE_DISPATCH_TIMEOUT_EN. When defined, a core that
// stays busy for TIMEOUT_CYCLES cycles without done is forced idle and flagged.
module core_dispatcher #(
    parameter int unsigned CORES          = 2,
    parameter int unsigned INST_WIDTH     = 32,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INST_WIDTH-1:0]         in_inst,
    output logic [CORES-1:0]              core_start,
    output logic [INST_WIDTH-1:0]         core_inst,
    input  logic [CORES-1:0]              core_done,
    output logic [CORES-1:0]              core_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          idle
`ifdef CORE_DISPATCH_TIMEOUT_EN
    ,
    output logic [CORES-1:0]              timeout_err
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = (CORES > 1) ? $clog2(CORES) : 1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    logic [INST_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic [CORES-1:0]      state_q, state_d;
    logic [CORES-1:0]      start_q, start_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [PW-1:0]         rr_q, rr_d;

    logic                  push, pop;
    logic                  grant_valid;
    int unsigned           grant_idx;
    logic [CORES-1:0]      eligible;

    // A core is eligible only when idle and not being started this cycle.
    assign eligible = ~state_q & ~start_q;
    assign in_ready = (count_q != CW'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;

    // Round-robin search upward from rr_q, wrapping at CORES-1.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 0;
        for (int unsigned k = 0; k < CORES; k++) begin
            int unsigned idx;
            idx = int'(rr_q) + k;
            if (idx >= CORES) idx = idx - CORES;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    assign pop = grant_valid && (count_q != '0);

    always_comb begin
        start_d = '0;
        inst_d  = inst_q;
        rr_d    = rr_q;
        if (pop) begin
            start_d[grant_idx] = 1'b1;
            inst_d             = mem_q[rd_ptr_q];
            rr_d               = (grant_idx + 1 >= CORES) ? '0 : PW'(grant_idx + 1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

`ifdef CORE_DISPATCH_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]    tcnt_q [CORES];
    logic [TW-1:0]    tcnt_d [CORES];
    logic [CORES-1:0] terr_q, terr_d;
`endif

    always_comb begin
`ifdef CORE_DISPATCH_TIMEOUT_EN
        terr_d = terr_q;
`endif
        for (int unsigned i = 0; i < CORES; i++) begin
            state_d[i] = state_q[i];
`ifdef CORE_DISPATCH_TIMEOUT_EN
            tcnt_d[i] = tcnt_q[i];
            if (start_q[i]) begin
                tcnt_d[i] = '0;
            end else if (state_q[i] == ST_BUSY) begin
                tcnt_d[i] = tcnt_q[i] + 1'b1;
            end
`endif
            if (start_q[i]) begin
                state_d[i] = ST_BUSY;
            end else if (state_q[i] == ST_BUSY && core_done[i]) begin
                state_d[i] = ST_IDLE;
`ifdef CORE_DISPATCH_TIMEOUT_EN
            end else if (state_q[i] == ST_BUSY && tcnt_q[i] == TW'(TIMEOUT_CYCLES - 1)) begin
                // TIMEOUT_CYCLES busy cycles elapsed with no done: release the core.
                state_d[i] = ST_IDLE;
                terr_d[i]  = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= {CORES{ST_IDLE}};
            start_q  <= '0;
            inst_q   <= '0;
            rr_q     <= '0;
        end else begin
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            count_q <= count_d;
            state_q <= state_d;
            start_q <= start_d;
            inst_q  <= inst_d;
            rr_q    <= rr_d;
        end
    end

`ifdef CORE_DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            terr_q <= '0;
            for (int unsigned i = 0; i < CORES; i++) tcnt_q[i] <= '0;
        end else begin
            terr_q <= terr_d;
            for (int unsigned i = 0; i < CORES; i++) tcnt_q[i] <= tcnt_d[i];
        end
    end
    assign timeout_err = terr_q;
`endif

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_inst;
    end

    assign core_start = start_q;
    assign core_inst  = inst_q;
    assign core_busy  = state_q;
    assign fifo_count = count_q;
    assign idle       = (count_q == '0) && (state_q == '0) && (start_q == '0);

endmodule

// File: tb/tb_core_dispatcher.sv
// Randomized bench for core_dispatcher (default build, CORES=2, FIFO_DEPTH=4)
// compared cycle by cycle against a queue-based reference model.
module tb_core_dispatcher;

    localparam int CORES = 2;
    localparam int IW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [IW-1:0]     in_inst;
    logic [CORES-1:0]  core_start;
    logic [IW-1:0]     core_inst;
    logic [CORES-1:0]  core_done;
    logic [CORES-1:0]  core_busy;
    logic [CW-1:0]     fifo_count;
    logic              idle;

    core_dispatcher #(
        .CORES      (CORES),
        .INST_WIDTH (IW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .core_start (core_start),
        .core_inst  (core_inst),
        .core_done  (core_done),
        .core_busy  (core_busy),
        .fifo_count (fifo_count),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: instruction queue, per-core busy, pending start pulse.
    logic [IW-1:0] m_q[$];
    bit            m_busy  [CORES];
    bit            m_start [CORES];
    logic [IW-1:0] m_inst;
    int            m_rr;

    function automatic void model_reset();
        m_q.delete();
        for (int i = 0; i < CORES; i++) begin
            m_busy[i]  = 0;
            m_start[i] = 0;
        end
        m_inst = '0;
        m_rr   = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [IW-1:0] d,
                                       input logic [CORES-1:0] done);
        bit full;
        bit nstart [CORES];
        int g;
        full = (m_q.size() == DEPTH);
        g    = -1;
        for (int k = 0; k < CORES; k++) begin
            int c;
            c = (m_rr + k) % CORES;
            if (g < 0 && !m_busy[c] && !m_start[c]) g = c;
        end
        for (int i = 0; i < CORES; i++) nstart[i] = 0;
        if (m_q.size() > 0 && g >= 0) begin
            nstart[g] = 1;
            m_inst    = m_q.pop_front();
            m_rr      = (g + 1) % CORES;
        end
        for (int i = 0; i < CORES; i++) begin
            if (m_start[i])                m_busy[i] = 1;
            else if (m_busy[i] && done[i]) m_busy[i] = 0;
        end
        if (v && !full) m_q.push_back(d);
        for (int i = 0; i < CORES; i++) m_start[i] = nstart[i];
    endfunction

    function automatic logic [CORES-1:0] vec_of(input bit a [CORES]);
        logic [CORES-1:0] r;
        for (int i = 0; i < CORES; i++) r[i] = a[i];
        return r;
    endfunction

    task automatic compare_outputs(input string ph);
        logic [CORES-1:0] es, eb;
        es = vec_of(m_start);
        eb = vec_of(m_busy);
        check_eq({ph, ".in_ready"},   in_ready,   m_q.size() != DEPTH);
        check_eq({ph, ".fifo_count"}, fifo_count, m_q.size());
        check_eq({ph, ".core_start"}, core_start, es);
        check_eq({ph, ".core_busy"},  core_busy,  eb);
        check_eq({ph, ".core_inst"},  core_inst,  m_inst);
        check_eq({ph, ".idle"}, idle, (m_q.size() == 0) && (eb == '0) && (es == '0));
    endtask

    // Asserted away from a clock edge; outputs must clear before the next edge.
    task automatic async_reset(input string ph);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_outputs(ph);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic              v;
        logic [IW-1:0]     d;
        logic [CORES-1:0]  dn;
        int                vprob, dprob;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inst   = '0;
        core_done = '0;
        v         = 1'b0;
        d         = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 compare_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Phases vary push and done density: sparse, saturating, done-starved.
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0:       begin vprob = 30; dprob = 60; end
                1:       begin vprob = 90; dprob = 40; end
                2:       begin vprob = 95; dprob = 5;  end
                default: begin vprob = 60; dprob = 25; end
            endcase
            for (int cyc = 0; cyc < 200; cyc++) begin
                if (ph == 2 && cyc == 60) async_reset("midreset");
                else @(negedge clk);
                // Hold a stalled request unchanged until it is accepted.
                if (!(v && m_q.size() == DEPTH)) begin
                    v = ($urandom_range(99) < vprob);
                    d = $urandom();
                end
                for (int i = 0; i < CORES; i++) dn[i] = ($urandom_range(99) < dprob);
                in_valid  = v;
                in_inst   = d;
                core_done = dn;
                #1 compare_outputs($sformatf("p%0d", ph));
                @(posedge clk);
                model_step(v, d, dn);
            end
        end

        // Drain with all dones active; everything must end idle.
        @(negedge clk);
        in_valid = 1'b0;
        v        = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            core_done = '1;
            @(posedge clk);
            model_step(1'b0, '0, '1);
            @(negedge clk);
        end
        core_done = '0;
        #1 compare_outputs("drain");
        check_eq("drain.idle_final", idle, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_dispatcher.md
Name: core_dispatcher

Overview:
- Schedules decoded instructions onto the parallel matrix-core array inside the core socket.
- Buffers instructions from the instruction decoder in a small FIFO and issues each one to an idle core.
  - Core choice is round-robin.
  - Each core's busy/idle state is tracked from its done pulse.
- Sits between the decoder output and the start/instruction inputs of the matrix cores.

Parameters:
- CORES, 2: number of matrix cores scheduled; 1..8.
- INST_WIDTH, 32: width of one decoded instruction word.
- FIFO_DEPTH, 4: instruction buffer entries; power of two, >= 2.
- TIMEOUT_CYCLES, 1024: busy-cycle limit per dispatch; used only with the optional feature.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: decoder presents an instruction.
- in_ready, output, 1: buffer can accept an instruction.
- in_inst, input, INST_WIDTH: decoded instruction.
- core_start, output, CORES: one-hot, one-cycle start pulse to the selected core.
- core_inst, output, INST_WIDTH: shared instruction bus to the cores; valid while core_start != 0.
- core_done, input, CORES: per-core one-cycle completion pulse.
- core_busy, output, CORES: per-core busy flag.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: number of buffered instructions.
- idle, output, 1: FIFO empty and no core busy.
- timeout_err, output, CORES: per-core sticky timeout flag; present only with the optional feature.

Behaviour:
- Reset (asynchronous, any time, including mid-dispatch):
  - FIFO is emptied; fifo_count=0.
  - core_start=0, core_inst=0, core_busy=0.
  - Round-robin pointer=0, in_ready=1, idle=1.
  - In-flight instructions are dropped.
- Input handshake:
  - Push occurs when in_valid && in_ready.
  - in_ready = (fifo_count != FIFO_DEPTH), combinational from registered state.
  - in_inst must be held while in_valid=1 and in_ready=0.
- Per-core FSM, two states:
  - IDLE -> BUSY on the cycle after core_start[i].
  - BUSY -> IDLE on the cycle after core_done[i].
  - core_busy[i]=1 in BUSY.
  - core_done[i] while IDLE is ignored.
- Dispatch (registered):
  - Each cycle where the FIFO is non-empty and any core is IDLE with core_start[i]=0 this cycle:
    - Grant goes to the first idle core searching upward from the pointer, wrapping at CORES-1 -> 0.
    - Next cycle: core_start[grant]=1 and core_inst=FIFO head; the head is popped.
    - The pointer becomes grant+1, modulo CORES.
  - At most one dispatch per cycle.
  - core_inst holds its last value when no start is issued.
- Latency:
  - An instruction pushed at edge N into an empty FIFO, with an idle core, gives core_start at cycle N+1.
  - Back-to-back dispatch is possible every cycle while idle cores and FIFO entries exist.
- A core whose done is sampled at edge C becomes eligible at edge C+1; it is never re-dispatched in the same cycle its done is sampled.
- Push and pop in the same cycle: fifo_count unchanged, FIFO order preserved.
- Full FIFO: in_ready=0 and no push, even if a pop occurs that cycle.
- Empty FIFO: no start issued; cores finish normally.
- Wrap-around: FIFO read/write pointers wrap modulo FIFO_DEPTH; the count distinguishes full from empty.
- idle=1 iff fifo_count==0 and core_busy==0 and core_start==0; registered-consistent with the other outputs.

Optional Feature:
- Macro: CORE_DISPATCH_TIMEOUT_EN.
- When defined:
  - Each core has a busy-cycle counter, cleared on dispatch.
  - If a core stays BUSY for TIMEOUT_CYCLES cycles without core_done:
    - timeout_err[i] sets; it is sticky until rst.
    - The core is forced to IDLE and can be rescheduled.
    - A late core_done from that core is ignored while it is IDLE.
- When not defined: no counters, no timeout_err port, and cores stay BUSY until done.

Test Plan:
- Reset then idle check -> in_ready=1, idle=1, core_busy=0, fifo_count=0, core_start=0.
- CORES=2: push 0xA1 at cycle 0 -> core_start=2'b01, core_inst=0xA1 at cycle 1; core_busy=2'b01 at cycle 2.
- Push 0xB1,0xB2,0xB3 back-to-back with no done:
  - Starts go to core0 then core1.
  - fifo_count settles at 1.
  - core_done[0] pulse -> 0xB3 to core0 exactly one cycle after done is sampled.
- Fill FIFO with 4 entries while all cores busy -> in_ready=0, the 5th push is stalled and held; one done frees one entry and in_ready returns to 1.
- Assert rst while both cores are busy and fifo_count=3 -> all outputs return to reset values immediately; a later core_done is ignored.
- With CORE_DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES=16: core0 never sends done -> timeout_err[0]=1 after 16 busy cycles, core_busy[0]=0, and the next instruction can go to core0.
